instr_encoder: RTL and testbench

Reverse of the immediate generator: takes a decoded instruction description (kind, register fields, funct fields, 32-bit immediate) and packs it into a 32-bit RV32I instruction word. Handles the `LI` pseudo-op by emitting up to two words: LUI, then ADDI. Sits between the test-program/boot-ROM generator and instruction memory, with valid/ready on both sides. Flags immediates that are not representable.

---
 rtl/riscv_enc_pkg.sv | 29 ++
 rtl/instr_pack.sv | 61 ++++++
 rtl/instr_encoder.sv | 136 +++++++++++++
 tb/tb_instr_encoder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package riscv_enc_pkg;

  typedef enum logic [3:0] {
    KindR, KindI, KindLoad, KindS, KindB, KindLui, KindAuipc, KindJal, KindJalr, KindLi
  } kind_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam int Imm12Min = -2048;
  localparam int Imm12Max = 2047;
  localparam int BrMin    = -4096;
  localparam int BrMax    = 4094;
  localparam int JalMin   = -(1 << 20);
  localparam int JalMax   = (1 << 20) - 2;

  function automatic logic fits_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: one decoded instruction description into one RV32I word plus a
// range/alignment error flag. LI is resolved by the caller before reaching here.
module instr_pack
  import riscv_enc_pkg::*;
(
  input  kind_e       kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        err_o
);

  always_comb begin
    word_o = '0;
    err_o  = 1'b0;
    case (kind_i)
      KindR: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
      KindI: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
        err_o  = !fits_range(imm_i, Imm12Min, Imm12Max);
      end
      KindLoad: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_LOAD};
        err_o  = !fits_range(imm_i, Imm12Min, Imm12Max);
      end
      KindJalr: begin
        word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_JALR};
        err_o  = !fits_range(imm_i, Imm12Min, Imm12Max);
      end
      KindS: begin
        word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_S};
        err_o  = !fits_range(imm_i, Imm12Min, Imm12Max);
      end
      KindB: begin
        word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], OP_B};
        err_o  = !fits_range(imm_i, BrMin, BrMax) || imm_i[0];
      end
      KindLui: begin
        word_o = {imm_i[31:12], rd_i, OP_LUI};
        err_o  = (imm_i[11:0] != 12'h000);
      end
      KindAuipc: begin
        word_o = {imm_i[31:12], rd_i, OP_AUIPC};
        err_o  = (imm_i[11:0] != 12'h000);
      end
      KindJal: begin
        word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        err_o  = !fits_range(imm_i, JalMin, JalMax) || imm_i[0];
      end
      default: begin
        word_o = '0;
        err_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Valid/ready RV32I instruction encoder with LI pseudo-op expansion into LUI + ADDI.
module instr_encoder
  import riscv_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  typedef enum logic [0:0] {StIdle, StLi2} state_e;

  state_e      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        out_err_q, out_err_d;
  logic        out_last_q, out_last_d;
  logic [31:0] addi_q, addi_d;

  kind_e       req_kind, pack_kind;
  logic        is_li, li_fit12, li_two, accept;
  logic [31:0] li_sum, pack_imm, pack_word;
  logic [4:0]  pack_rs1;
  logic [2:0]  pack_funct3;
  logic        pack_err;

  assign req_kind = kind_e'(in_kind);
  assign is_li    = (req_kind == KindLi);
  assign li_fit12 = fits_range(in_imm, Imm12Min, Imm12Max);
  assign li_two   = is_li && !li_fit12 && (in_imm[11:0] != 12'h000);
  // Rounding the upper part compensates for the sign-extended low 12 bits of the ADDI.
  assign li_sum   = in_imm + 32'h0000_0800;

  always_comb begin
    pack_kind   = req_kind;
    pack_rs1    = in_rs1;
    pack_funct3 = in_funct3;
    pack_imm    = in_imm;
    if (is_li) begin
      pack_rs1    = '0;
      pack_funct3 = '0;
      if (li_fit12) begin
        pack_kind = KindI;
      end else begin
        pack_kind = KindLui;
        pack_imm  = {li_sum[31:12], 12'h000};
      end
    end
  end

  instr_pack u_pack (
    .kind_i   (pack_kind),
    .rd_i     (in_rd),
    .rs1_i    (pack_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (pack_funct3),
    .funct7_i (in_funct7),
    .imm_i    (pack_imm),
    .word_o   (pack_word),
    .err_o    (pack_err)
  );

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    out_last_d  = out_last_q;
    addi_d      = addi_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_instr_d = pack_word;
          out_err_d   = pack_err && !is_li;
          out_last_d  = !li_two;
          if (li_two) begin
            addi_d  = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_I};
            state_d = StLi2;
          end
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      StLi2: begin
        if (out_ready) begin
          out_valid_d = 1'b1;
          out_instr_d = addi_q;
          out_err_d   = 1'b0;
          out_last_d  = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      out_last_q  <= 1'b0;
      addi_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      out_last_q  <= out_last_d;
      addi_q      <= addi_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized requests checked by
// decoding the emitted words and by executing LI sequences on a tiny register model.
module tb_instr_encoder;

  localparam logic [3:0] K_R = 4'd0, K_I = 4'd1, K_LOAD = 4'd2, K_S = 4'd3, K_B = 4'd4;
  localparam logic [3:0] K_LUI = 4'd5, K_AUIPC = 4'd6, K_JAL = 4'd7, K_JALR = 4'd8, K_LI = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, out_err, out_last;
  logic [31:0] out_instr;

  int n_cmp = 0;
  int n_bad = 0;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_opcode(input logic [3:0] k);
    case (k)
      K_R:     return 7'h33;
      K_I:     return 7'h13;
      K_LOAD:  return 7'h03;
      K_S:     return 7'h23;
      K_B:     return 7'h63;
      K_LUI:   return 7'h37;
      K_AUIPC: return 7'h17;
      K_JAL:   return 7'h6F;
      K_JALR:  return 7'h67;
      default: return 7'h00;
    endcase
  endfunction

  // Immediate generator as used by the core's decoder.
  function automatic logic [31:0] imm_gen(input logic [31:0] w);
    case (w[6:0])
      7'h13, 7'h03, 7'h67: return {{20{w[31]}}, w[31:20]};
      7'h23:               return {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63:               return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      7'h37, 7'h17:        return {w[31:12], 12'h000};
      7'h6F:               return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default:             return 32'h0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [3:0] k, input logic [31:0] imm);
    int v;
    v = $signed(imm);
    case (k)
      K_I, K_LOAD, K_JALR, K_S: return (v < -2048) || (v > 2047);
      K_B:                      return (v < -4096) || (v > 4094) || imm[0];
      K_JAL:                    return (v < -1048576) || (v > 1048574) || imm[0];
      K_LUI, K_AUIPC:           return imm[11:0] != 12'h000;
      default:                  return 1'b0;
    endcase
  endfunction

  // Execute up to two LUI/ADDI words on a zeroed register file and return rd.
  function automatic logic [31:0] li_exec(input int n, input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] rd);
    logic [31:0] x [32];
    logic [31:0] w, r;
    for (int i = 0; i < 32; i++) x[i] = 32'h0;
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? a : b;
      if (w[6:0] == 7'h37) r = {w[31:12], 12'h000};
      else if (w[6:0] == 7'h13 && w[14:12] == 3'b000) r = x[w[19:15]] + {{20{w[31]}}, w[31:20]};
      else r = 32'hDEAD_BEEF;
      if (w[11:7] != 5'd0) x[w[11:7]] = r;
    end
    return x[rd];
  endfunction

  function automatic logic [31:0] rand_imm();
    logic [31:0] edges [16];
    edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095, -32'sd4096,
              -32'sd4098, 32'h000F_FFFE, 32'h0010_0000, 32'hFFF0_0000, 32'hFFEF_FFFE,
              32'h0000_0800, 32'hFFFF_F800, 32'h7FFF_F800, 32'h8000_0000};
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 4095)) - 32'd2048;
      2:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      3:       return 32'($urandom_range(0, 2097151)) - 32'd1048576;
      4:       return {$urandom_range(0, 1048575) > 0 ? 20'($urandom) : 20'h0, 12'h000};
      default: return edges[$urandom_range(0, 15)];
    endcase
  endfunction

  int          n;
  logic [31:0] w0, w1;
  logic        l0, l1, e0, e1, mr;

  // Present one request with out_ready=1 and collect the words it produces.
  task automatic issue(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
    logic done;
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    @(negedge clk);
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0; w0 = '0; w1 = '0; l0 = 1'b0; l1 = 1'b0; e0 = 1'b0; e1 = 1'b0; mr = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 4 && !done; c++) begin
      if (out_valid) begin
        if (n == 0) begin
          w0 = out_instr; l0 = out_last; e0 = out_err; mr = in_ready;
        end else begin
          w1 = out_instr; l1 = out_last; e1 = out_err;
        end
        n++;
        if (out_last || n == 2) done = 1'b1;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    logic [3:0]  k;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ex;
    int          exp_n, v;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    issue(K_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    chk("addi_count", 32'(n), 32'd1);
    chk("addi_word", w0, 32'hFFF0_0093);
    chk("addi_err", 32'(e0), 32'd0);
    chk("addi_last", 32'(l0), 32'd1);

    issue(K_B, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8);
    chk("beq_word", w0, 32'hFE20_8CE3);
    chk("beq_err", 32'(e0), 32'd0);
    issue(K_B, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd7);
    chk("beq_odd_err", 32'(e0), 32'd1);

    issue(K_LI, 5'd5, 5'd3, 5'd4, 3'd7, 7'd0, 32'h1234_5FFF);
    chk("li2_count", 32'(n), 32'd2);
    chk("li2_lui", w0, 32'h1234_62B7);
    chk("li2_lui_last", 32'(l0), 32'd0);
    chk("li2_mid_ready", 32'(mr), 32'd0);
    chk("li2_addi", w1, 32'hFFF2_8293);
    chk("li2_addi_last", 32'(l1), 32'd1);

    issue(K_LI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_07FF);
    chk("li_small_count", 32'(n), 32'd1);
    chk("li_small_word", w0, 32'h7FF0_0293);
    issue(K_LI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0001_0000);
    chk("li_upper_count", 32'(n), 32'd1);
    chk("li_upper_word", w0, 32'h0001_02B7);
    chk("li_upper_last", 32'(l0), 32'd1);

    // Backpressure, then a waiting request accepted on the consume edge.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_kind = K_I; in_rd = 5'd1; in_rs1 = 5'd0; in_funct3 = 3'd0; in_imm = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_rd = 5'd2; in_imm = 32'd5;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_word_stable", out_instr, 32'hFFF0_0093);
      chk("bp_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_word", out_instr, 32'h0050_0113);
    @(posedge clk); #1;
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset while the LUI half of a two-word LI is held.
    out_ready = 1'b0;
    in_kind = K_LI; in_rd = 5'd5; in_imm = 32'h1234_5FFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rli_lui", out_instr, 32'h1234_62B7);
    chk("rli_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("rli_lui_hold", out_instr, 32'h1234_62B7);
    rst_n = 1'b0;
    #1;
    chk("rli_valid_clr", 32'(out_valid), 32'd0);
    chk("rli_instr_clr", out_instr, 32'd0);
    chk("rli_last_clr", 32'(out_last), 32'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rli_no_addi", 32'(out_valid), 32'd0);
      chk("rli_ready_after", 32'(in_ready), 32'd1);
    end

    // Randomized requests.
    for (int t = 0; t < 200; t++) begin
      k   = 4'($urandom_range(0, 9));
      rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      f3  = 3'($urandom); f7  = 7'($urandom);
      imm = rand_imm();
      if (k == K_LI) begin
        rd = 5'($urandom_range(1, 31));
        issue(k, rd, rs1, rs2, f3, f7, imm);
        v = $signed(imm);
        exp_n = (v >= -2048 && v <= 2047) || imm[11:0] == 12'h000 ? 1 : 2;
        chk("rnd_li_count", 32'(n), 32'(exp_n));
        chk("rnd_li_value", li_exec(n, w0, w1, rd), imm);
        chk("rnd_li_err", {30'd0, e1, e0}, 32'd0);
        chk("rnd_li_last", {30'd0, l1, l0}, exp_n == 2 ? 32'd2 : 32'd1);
      end else begin
        issue(k, rd, rs1, rs2, f3, f7, imm);
        ex = ref_err(k, imm);
        chk("rnd_count", 32'(n), 32'd1);
        chk("rnd_last", 32'(l0), 32'd1);
        chk("rnd_err", 32'(e0), 32'(ex));
        chk("rnd_opcode", 32'(w0[6:0]), 32'(ref_opcode(k)));
        if (k != K_S && k != K_B) chk("rnd_rd", 32'(w0[11:7]), 32'(rd));
        if (k != K_LUI && k != K_AUIPC && k != K_JAL) begin
          chk("rnd_rs1", 32'(w0[19:15]), 32'(rs1));
          chk("rnd_f3", 32'(w0[14:12]), 32'(f3));
        end
        if (k == K_R || k == K_S || k == K_B) chk("rnd_rs2", 32'(w0[24:20]), 32'(rs2));
        if (k == K_R) chk("rnd_f7", 32'(w0[31:25]), 32'(f7));
        if (k != K_R && !ex) chk("rnd_imm_roundtrip", imm_gen(w0), imm);
      end
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
